// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM encodings,
// default reset PC, bubble word and the IF/ID bundle.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, flush and load.
// A flush keeps pc4 so ID still sees the last link value.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // hold beats flush beats load; nothing asserted also holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.inst  <= NOP_INST;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (hold) begin
            q <= q;
        end else if (flush) begin
            q.inst  <= NOP_INST;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, next-PC
// selection and the IF/ID register instance.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        addr_err
);

    if_state_e   state;
    if_state_e   state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] pc4;
    logic        err_n;
    logic        hold;
    logic        flush;
    logic        load;
    if_id_t      d;
    if_id_t      q;

    assign pc4     = pc + 32'd4;
    assign im_req  = (state == IF_RUN);
    assign im_addr = pc;
    assign halted  = (state == IF_HALT);

    // Per-edge priority: halt, halted, stall, redirect, fetch, bubble
    always_comb begin
        state_n = state;
        pc_n    = pc;
        err_n   = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        load    = 1'b0;
        if (state == IF_BOOT) begin
            state_n = IF_RUN;
        end
        if (halt) begin
            state_n = IF_HALT;
            flush   = 1'b1;
        end else if (state == IF_HALT) begin
            flush   = 1'b1;
        end else if (stall) begin
            hold    = 1'b1;
        end else if (redirect) begin
            pc_n    = word_align(redirect_pc);
            err_n   = |redirect_pc[1:0];
            flush   = 1'b1;
        end else if (state == IF_RUN && im_ready) begin
            pc_n    = pc4;
            load    = 1'b1;
        end else begin
            flush   = 1'b1;
        end
    end

    // PC, FSM state and the one-cycle alignment error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IF_BOOT;
            pc       <= RESET_PC;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            addr_err <= err_n;
        end
    end

    assign d.inst  = im_rdata;
    assign d.pc4   = pc4;
    assign d.valid = 1'b1;

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (hold),
        .flush(flush),
        .load (load),
        .d    (d),
        .q    (q)
    );

    assign if_id_inst  = q.inst;
    assign if_id_pc4   = q.pc4;
    assign if_id_valid = q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table applied
// one edge at a time, plus halt and async-reset sequences.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        addr_err;

    int errors;
    int checks;

    typedef struct {
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        hlt;
        logic        rdy;
        logic [31:0] addr;
        logic        req;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic        hltd;
    } vec_t;

    vec_t vt[$];

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ready   (im_ready),
        .im_rdata   (im_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .if_id_inst (if_id_inst),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid),
        .halted     (halted),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h2008_0005;
            32'h0000_3004: return 32'h0000_000C;
            default:       return a ^ 32'h1234_5678;
        endcase
    endfunction

    always_comb im_rdata = mem(im_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic stl, input logic rdr, input logic [31:0] rpc,
        input logic hlt, input logic rdy, input logic [31:0] addr,
        input logic req, input logic [31:0] inst,
        input logic [31:0] pc4, input logic valid,
        input logic err, input logic hltd);
        vec_t v;
        v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
        v.rdy = rdy; v.addr = addr; v.req = req; v.inst = inst;
        v.pc4 = pc4; v.valid = valid; v.err = err; v.hltd = hltd;
        return v;
    endfunction

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".addr"},  im_addr, v.addr);
        chk({tag, ".req"},   {31'd0, im_req}, {31'd0, v.req});
        chk({tag, ".inst"},  if_id_inst, v.inst);
        chk({tag, ".pc4"},   if_id_pc4, v.pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v.valid});
        chk({tag, ".err"},   {31'd0, addr_err}, {31'd0, v.err});
        chk({tag, ".halted"},{31'd0, halted}, {31'd0, v.hltd});
    endtask

    task automatic do_reset();
        stall = 0; redirect = 0; redirect_pc = 0;
        halt = 0; im_ready = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        halt = 0; im_ready = 1; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_all("reset", mk(0,0,0,0,0, 32'h3000,0,0,0,0,0,0));
        step();
        rst_n = 1'b1;
        #1;
        chk("boot.req", {31'd0, im_req}, 32'd0);

        // stall rdr rpc halt rdy | addr req inst pc4 valid err halted
        vt.push_back(mk(0,0,0,0,1, 32'h3000,1,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3004,1,32'h2008_0005,32'h3004,1,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3008,1,32'h0000_000C,32'h3008,1,0,0));
        vt.push_back(mk(0,0,0,0,0, 32'h3008,1,0,32'h3008,0,0,0));
        vt.push_back(mk(0,1,32'h3100,0,0, 32'h3100,1,0,32'h3008,0,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3104,1,mem(32'h3100),32'h3104,1,0,0));
        vt.push_back(mk(0,1,32'h3000,0,1, 32'h3000,1,0,32'h3104,0,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3004,1,32'h2008_0005,32'h3004,1,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3008,1,32'h0000_000C,32'h3008,1,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h300C,1,mem(32'h3008),32'h300C,1,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3010,1,mem(32'h300C),32'h3010,1,0,0));
        vt.push_back(mk(1,0,0,0,1, 32'h3010,1,mem(32'h300C),32'h3010,1,0,0));
        vt.push_back(mk(1,1,32'h3200,0,1, 32'h3010,1,mem(32'h300C),32'h3010,1,0,0));
        vt.push_back(mk(1,0,0,0,1, 32'h3010,1,mem(32'h300C),32'h3010,1,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3014,1,mem(32'h3010),32'h3014,1,0,0));
        vt.push_back(mk(0,1,32'h3042,0,1, 32'h3040,1,0,32'h3014,0,1,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3044,1,mem(32'h3040),32'h3044,1,0,0));
        vt.push_back(mk(0,1,32'h3040,0,1, 32'h3040,1,0,32'h3044,0,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h3044,1,mem(32'h3040),32'h3044,1,0,0));
        vt.push_back(mk(0,1,32'hFFFF_FFFC,0,1, 32'hFFFF_FFFC,1,0,32'h3044,0,0,0));
        vt.push_back(mk(0,0,0,0,1, 32'h0,1,mem(32'hFFFF_FFFC),32'h0,1,0,0));
        vt.push_back(mk(0,1,32'h3000,0,1, 32'h3000,1,0,32'h0,0,0,0));
        vt.push_back(mk(0,1,32'h3300,1,1, 32'h3000,0,0,32'h0,0,0,1));

        for (int i = 0; i < vt.size(); i++) begin
            stall       = vt[i].stl;
            redirect    = vt[i].rdr;
            redirect_pc = vt[i].rpc;
            halt        = vt[i].hlt;
            im_ready    = vt[i].rdy;
            step();
            check_all($sformatf("v%0d", i), vt[i]);
        end

        // halted state survives redirect pulses
        halt = 0;
        for (int i = 0; i < 10; i++) begin
            redirect    = i[0];
            redirect_pc = 32'h3400;
            im_ready    = 1;
            step();
            check_all($sformatf("halt%0d", i),
                      mk(0,0,0,0,0, 32'h3000,0,0,32'h0,0,0,1));
        end

        // async reset while waiting on memory
        do_reset();
        #1;
        chk("rst2.req", {31'd0, im_req}, 32'd0);
        step();
        redirect = 1; redirect_pc = 32'h3100; im_ready = 0;
        step();
        redirect = 0;
        step();
        chk("wait.req", {31'd0, im_req}, 32'd1);
        chk("wait.addr", im_addr, 32'h3100);
        chk("wait.valid", {31'd0, if_id_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req", {31'd0, im_req}, 32'd0);
        chk("arst.addr", im_addr, 32'h3000);
        chk("arst.halted", {31'd0, halted}, 32'd0);
        step();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
